inverse_cdf_sign_restore: RTL and testbench
===========================================

# inverse_cdf_sign_restore

Final stage of the inverse-CDF pipeline, and the consumer of the fold performed at its entry. The entry stage maps each Sobol sample into (0, 0.5] and emits a `negate` flag. This block queues those flags in issue order. It pairs each flag with the unsigned z-magnitude that leaves the rational-approximation stages, and emits a signed, saturated Q16.16 z-score through a valid/ready output register.

## Interface
Parameters:
- `WIDTH`, default `fpga_cfg_pkg::FP_WIDTH` (32): data width.
- `QINT`, default `fpga_cfg_pkg::FP_QINT`: integer bits. Informational only.
- `QFRAC`, default `fpga_cfg_pkg::FP_QFRAC` (16): fraction bits.
- `FLAG_DEPTH`, default 16: flag FIFO entries. Must be a power of two, ≥2.

Ports (one clock; reset is asynchronous and active-low):
- `clk`  in  1  clock.
- `rst_n`  in  1  asynchronous active-low reset.
- `flag_valid_in`  in  1  negate flag offered by the entry stage.
- `flag_in`  in  1  1 means the final z is negated.
- `flag_ready_out`  out  1  flag FIFO not full.
- `valid_in`  in  1  magnitude offered by the upstream stage.
- `z_mag`  in  WIDTH  unsigned Q16.16 |z|.
- `ready_out`  out  1  upstream ready. Magnitude accepted this cycle.
- `valid_out`  out  1  `z` valid.
- `ready_in`  in  1  downstream ready.
- `z`  out  WIDTH  signed Q16.16 z-score.
- `sat`  out  1  `z` was clamped. Qualified by `valid_out`.
- `flag_count`  out  $clog2(FLAG_DEPTH)+1  FIFO occupancy.

## Operation
- **Flag FIFO**: circular buffer with a write pointer, a read pointer and a count.
  - `flag_ready_out = (count != FLAG_DEPTH)`.
  - A push occurs when `flag_valid_in && flag_ready_out`.
  - Pointers wrap modulo FLAG_DEPTH.
- **Pairing**:
  - `ready_out = (count != 0) && (!valid_out || ready_in)`.
  - An accept (`valid_in && ready_out`) pops one flag and loads the output register in the same cycle.
  - There is no bypass. A flag pushed in cycle N is poppable from cycle N+1.
  - With an empty FIFO, magnitudes stall (`ready_out` = 0). They are never dropped or paired with a stale flag.
- **Simultaneous push and pop**: pointers both advance and count is unchanged. A full FIFO cannot accept a push, so there is no full+push case. An empty FIFO cannot pop, so there is no empty+pop case.
- **Arithmetic**, with MAXP = 2^(WIDTH-1)-1:
  - If `z_mag` > MAXP, the magnitude is clamped to MAXP and `sat` = 1. Otherwise `sat` = 0.
  - If the flag is 1, `z` = −clamped (two's complement). If the flag is 0, `z` = clamped.
  - The result range is symmetric [−MAXP, +MAXP]. 0x8000_0000 is never produced.
  - Magnitude 0 with flag 1 gives `z` = 0.
- **Output register**:
  - Loaded on accept, with `valid_out` set.
  - Cleared when `valid_out && ready_in && !accept`.
  - Accept and drain in the same cycle reload the register with `valid_out` staying 1, giving full throughput.
  - `z`/`sat` hold stable while `valid_out && !ready_in`.
- **Reset**: asynchronous. It takes effect immediately, including mid-stream.
  - `valid_out`=0, `z`=0, `sat`=0.
  - Pointers=0, `flag_count`=0, so `flag_ready_out`=1 and `ready_out`=0.
  - Queued flags are discarded. In-flight upstream magnitudes are the upstream stages' concern.

## Timing
- Latency: magnitude accepted at edge N gives `z` valid after edge N. One cycle.
- Throughput: one result per cycle while flags are available and `ready_in`=1.
- `ready_out` depends combinationally on `ready_in` and `count`. `flag_ready_out` depends only on registered state.
- `flag_count` updates on the edge after a push or pop.

## Test plan
- **Basic pairing**:
  - Push flags 0,1. Then present `z_mag` 0x0001_8000, 0x0000_4000 with `ready_in`=1.
  - Expect `z` = 0x0001_8000, then 0xFFFF_C000, on consecutive cycles.
  - Expect `sat`=0 and `flag_count` 2→1→0.
- **Empty stall**:
  - `valid_in`=1 with no flags queued. Expect `ready_out`=0 and `valid_out`=0.
  - Push flag 1 at cycle N. Expect the accept at cycle N+1, then `z`=−`z_mag`.
- **Backpressure**:
  - Hold `ready_in`=0 with a result pending. Expect `z`/`valid_out` stable and `ready_out`=0.
  - Release `ready_in`. Expect the next accept in that same cycle.
- **Full FIFO**:
  - Push 16 flags. Expect `flag_ready_out`=0 and an offered 17th flag ignored.
  - Then do simultaneous pop+push. Expect `flag_count` to stay 15 and FIFO order to be preserved across pointer wrap.
- **Saturation/sign edges**:
  - `z_mag`=0xFFFF_FFFF, flag 1 → `z`=0x8000_0001, `sat`=1.
  - `z_mag`=0x8000_0000, flag 0 → 0x7FFF_FFFF, `sat`=1.
  - `z_mag`=0, flag 1 → 0.
- **Reset mid-stream**:
  - With 5 flags queued and `valid_out`=1, drop `rst_n` asynchronously between edges.
  - Expect outputs and `flag_count` at 0 immediately. After release, the first result uses a newly pushed flag.

Source files
------------

// File: rtl/inverse_cdf_sign_restore.sv
// inverse_cdf_sign_restore: pairs queued negate flags with upstream |z| magnitudes
// and emits a signed, saturated Q16.16 z-score through a valid/ready output register.
`default_nettype none

module inverse_cdf_sign_restore #(
  parameter int WIDTH      = 32,
  parameter int QINT       = 16,
  parameter int QFRAC      = 16,
  parameter int FLAG_DEPTH = 16
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          flag_valid_in,
  input  logic                          flag_in,
  output logic                          flag_ready_out,
  input  logic                          valid_in,
  input  logic [WIDTH-1:0]              z_mag,
  output logic                          ready_out,
  output logic                          valid_out,
  input  logic                          ready_in,
  output logic [WIDTH-1:0]              z,
  output logic                          sat,
  output logic [$clog2(FLAG_DEPTH):0]   flag_count
);

  localparam int AW = $clog2(FLAG_DEPTH);
  localparam logic [AW:0]      c_DEPTH = FLAG_DEPTH[AW:0];
  localparam logic [AW:0]      c_CNT_ONE = 1;
  localparam logic [AW-1:0]    c_PTR_ONE = 1;
  localparam logic [WIDTH-1:0] c_MAXP = {1'b0, {(WIDTH-1){1'b1}}};

  logic            r_flags [FLAG_DEPTH];
  logic [AW-1:0]   r_wptr;
  logic [AW-1:0]   r_rptr;
  logic [AW:0]     r_count;
  logic            r_valid;
  logic [WIDTH-1:0] r_z;
  logic            r_sat;

  logic            w_push;
  logic            w_accept;
  logic            w_flag;
  logic            w_sat;
  logic [WIDTH-1:0] w_clamped;
  logic [WIDTH-1:0] w_z;

  assign flag_ready_out = (r_count != c_DEPTH);
  assign ready_out      = (r_count != '0) && (!r_valid || ready_in);
  assign w_push         = flag_valid_in && flag_ready_out;
  assign w_accept       = valid_in && ready_out;

  // Anything with the sign bit set exceeds MAXP; clamping keeps the range symmetric.
  assign w_flag    = r_flags[r_rptr];
  assign w_sat     = z_mag[WIDTH-1];
  assign w_clamped = w_sat ? c_MAXP : z_mag;
  assign w_z       = w_flag ? ({WIDTH{1'b0}} - w_clamped) : w_clamped;

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_flags[r_wptr] <= flag_in;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) begin
        r_wptr <= r_wptr + c_PTR_ONE;
      end
      if (w_accept) begin
        r_rptr <= r_rptr + c_PTR_ONE;
      end
      if (w_push && !w_accept) begin
        r_count <= r_count + c_CNT_ONE;
      end else if (!w_push && w_accept) begin
        r_count <= r_count - c_CNT_ONE;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= 1'b0;
      r_z     <= '0;
      r_sat   <= 1'b0;
    end else if (w_accept) begin
      r_valid <= 1'b1;
      r_z     <= w_z;
      r_sat   <= w_sat;
    end else if (r_valid && ready_in) begin
      r_valid <= 1'b0;
      r_z     <= '0;
      r_sat   <= 1'b0;
    end
  end

  assign valid_out  = r_valid;
  assign z          = r_z;
  assign sat        = r_sat;
  assign flag_count = r_count;

endmodule

`default_nettype wire

// File: tb/tb_inverse_cdf_sign_restore.sv
// Scoreboard bench for inverse_cdf_sign_restore: directed edge cases plus random traffic
// against a queue-based reference model.
`default_nettype none

module tb_inverse_cdf_sign_restore;

  localparam int  W     = 32;
  localparam int  DEPTH = 16;
  localparam longint MAXP = 64'h7FFF_FFFF;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          flag_valid_in = 1'b0;
  logic          flag_in = 1'b0;
  logic          flag_ready_out;
  logic          valid_in = 1'b0;
  logic [W-1:0]  z_mag = '0;
  logic          ready_out;
  logic          valid_out;
  logic          ready_in = 1'b0;
  logic [W-1:0]  z;
  logic          sat;
  logic [4:0]    flag_count;

  inverse_cdf_sign_restore #(
    .WIDTH(W), .QINT(16), .QFRAC(16), .FLAG_DEPTH(DEPTH)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .flag_valid_in(flag_valid_in), .flag_in(flag_in), .flag_ready_out(flag_ready_out),
    .valid_in(valid_in), .z_mag(z_mag), .ready_out(ready_out),
    .valid_out(valid_out), .ready_in(ready_in), .z(z), .sat(sat),
    .flag_count(flag_count)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  bit          mflags[$];
  bit          mvalid = 1'b0;
  logic [W:0]  exp_q[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: clamp the unsigned magnitude, then apply the sign arithmetically.
  function automatic logic [W:0] model(input logic [W-1:0] m, input bit neg);
    longint mag;
    bit     s;
    mag = longint'(m);
    s   = 1'b0;
    if (mag > MAXP) begin
      mag = MAXP;
      s   = 1'b1;
    end
    if (neg) mag = -mag;
    return {s, mag[W-1:0]};
  endfunction

  task automatic cycle(input bit fv, input bit f, input bit v, input logic [W-1:0] m, input bit r);
    bit exp_fr;
    bit exp_rdy;
    bit fl;
    @(negedge clk);
    flag_valid_in = fv;
    flag_in       = f;
    valid_in      = v;
    z_mag         = m;
    ready_in      = r;
    #3;
    exp_fr  = (mflags.size() < DEPTH);
    exp_rdy = (mflags.size() != 0) && (!mvalid || r);
    chk("flag_ready_out", flag_ready_out, exp_fr);
    chk("ready_out", ready_out, exp_rdy);
    chk("flag_count", flag_count, mflags.size());
    chk("valid_out", valid_out, mvalid);
    if (v && exp_rdy) begin
      fl = mflags.pop_front();
      exp_q.push_back(model(m, fl));
      mvalid = 1'b1;
    end else if (mvalid && r) begin
      mvalid = 1'b0;
    end
    if (fv && exp_fr) mflags.push_back(f);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(0, 0, 0, '0, 1);
  endtask

  function automatic logic [W-1:0] rand_mag();
    logic [W-1:0] r;
    case ($urandom_range(0, 7))
      0: r = '0;
      1: r = 32'hFFFF_FFFF;
      2: r = 32'h8000_0000;
      3: r = 32'h7FFF_FFFF;
      default: begin
        r = $urandom;
        r[W-1] = ($urandom_range(0, 3) == 0);
      end
    endcase
    return r;
  endfunction

  // Monitor: whenever a result is presented, it must match the oldest expected entry.
  initial begin
    forever begin
      @(negedge clk);
      #4;
      if (valid_out) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_valid", valid_out, 0);
        end else begin
          chk("z", z, exp_q[0][W-1:0]);
          chk("sat", sat, exp_q[0][W]);
          if (ready_in) void'(exp_q.pop_front());
        end
      end
    end
  end

  initial begin
    repeat (2) @(negedge clk);
    chk("reset_valid_out", valid_out, 0);
    chk("reset_z", z, 0);
    chk("reset_flag_count", flag_count, 0);
    chk("reset_flag_ready", flag_ready_out, 1);
    rst_n = 1'b1;

    // Basic pairing
    cycle(1, 0, 0, '0, 1);
    cycle(1, 1, 0, '0, 1);
    cycle(0, 0, 1, 32'h0001_8000, 1);
    cycle(0, 0, 1, 32'h0000_4000, 1);
    idle(2);

    // Empty stall, then a flag arrives while the magnitude waits
    repeat (3) cycle(0, 0, 1, 32'h0002_0000, 1);
    cycle(1, 1, 1, 32'h0002_0000, 1);
    cycle(0, 0, 1, 32'h0002_0000, 1);
    idle(2);

    // Backpressure
    cycle(1, 0, 0, '0, 1);
    cycle(1, 1, 0, '0, 1);
    cycle(0, 0, 1, 32'h0003_1234, 0);
    repeat (3) cycle(0, 0, 1, 32'h0000_0101, 0);
    cycle(0, 0, 1, 32'h0000_0101, 1);
    idle(2);

    // Full FIFO, rejected 17th push, then pop+push across pointer wrap
    repeat (DEPTH + 1) cycle(1, $urandom_range(0, 1), 0, '0, 1);
    repeat (20) cycle(1, $urandom_range(0, 1), 1, rand_mag(), 1);
    repeat (DEPTH + 1) cycle(0, 0, 1, rand_mag(), 1);
    idle(2);

    // Saturation / sign edges
    cycle(1, 1, 0, '0, 1);
    cycle(1, 0, 0, '0, 1);
    cycle(1, 1, 0, '0, 1);
    cycle(0, 0, 1, 32'hFFFF_FFFF, 1);
    cycle(0, 0, 1, 32'h8000_0000, 1);
    cycle(0, 0, 1, 32'h0000_0000, 1);
    idle(2);

    // Reset mid-stream with 5 flags queued and a result pending
    repeat (6) cycle(1, 1, 0, '0, 0);
    cycle(0, 0, 1, 32'h0000_5555, 0);
    @(negedge clk);
    flag_valid_in = 1'b0;
    valid_in      = 1'b1;
    ready_in      = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_valid_out", valid_out, 0);
    chk("midrst_z", z, 0);
    chk("midrst_sat", sat, 0);
    chk("midrst_flag_count", flag_count, 0);
    chk("midrst_flag_ready", flag_ready_out, 1);
    chk("midrst_ready_out", ready_out, 0);
    mflags.delete();
    exp_q.delete();
    mvalid = 1'b0;
    @(negedge clk);
    valid_in = 1'b0;
    rst_n    = 1'b1;
    cycle(1, 0, 1, 32'h0000_7777, 1);
    cycle(0, 0, 1, 32'h0000_7777, 1);
    idle(2);

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      cycle($urandom_range(0, 3) != 0, $urandom_range(0, 1),
            $urandom_range(0, 2) != 0, rand_mag(), $urandom_range(0, 3) != 0);
    end
    repeat (DEPTH + 2) cycle(0, 0, 1, rand_mag(), 1);
    idle(3);
    chk("scoreboard_empty", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
